// File: rtl/ipacket_fifo.sv
// Instruction buffer between IF and ID: DEPTH-entry {inst, pc} FIFO with pre-decoded head fields.
// Optional zero-latency bypass when empty is enabled by defining IPACKET_FIFO_BYPASS_EN.
module ipacket_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned PC_INC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_inst,
  input  logic [WIDTH-1:0]         in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_inst,
  output logic [WIDTH-1:0]         out_pc_next,
  output logic [3:0]               out_opcode,
  output logic [2:0]               out_dr,
  output logic [2:0]               out_sr1,
  output logic [2:0]               out_sr2,
  output logic                     out_writes_reg,
  output logic                     out_is_mem,
  output logic                     out_is_ctrl,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [3:0] OpBr  = 4'd0;
  localparam logic [3:0] OpAdd = 4'd1;
  localparam logic [3:0] OpLdb = 4'd2;
  localparam logic [3:0] OpStb = 4'd3;
  localparam logic [3:0] OpJsr = 4'd4;
  localparam logic [3:0] OpAnd = 4'd5;
  localparam logic [3:0] OpLdr = 4'd6;
  localparam logic [3:0] OpStr = 4'd7;
  localparam logic [3:0] OpRti = 4'd8;
  localparam logic [3:0] OpNot = 4'd9;
  localparam logic [3:0] OpLdi = 4'd10;
  localparam logic [3:0] OpSti = 4'd11;
  localparam logic [3:0] OpJmp = 4'd12;
  localparam logic [3:0] OpShf = 4'd13;
  localparam logic [3:0] OpLea = 4'd14;
  localparam logic [3:0] OpTrap = 4'd15;

  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem   [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic full, empty, bypass, push, pop;
  logic [WIDTH-1:0] head_inst, head_pc;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

`ifdef IPACKET_FIFO_BYPASS_EN
  assign bypass = empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken by ID the same cycle never enters storage.
  assign push = in_valid && !full && !flush && !(bypass && out_ready);
  assign pop  = !empty && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      inst_mem[wr_ptr_q] <= in_inst;
      pc_mem[wr_ptr_q]   <= in_pc;
    end
  end

  assign head_inst = bypass ? in_inst : inst_mem[rd_ptr_q];
  assign head_pc   = bypass ? in_pc   : pc_mem[rd_ptr_q];

  assign in_ready    = !full;
  assign out_valid   = !empty || bypass;
  assign out_inst    = head_inst;
  assign out_pc_next = head_pc + WIDTH'(PC_INC);
  assign out_opcode  = head_inst[15:12];
  assign out_sr1     = head_inst[8:6];
  assign count       = count_q;

  always_comb begin
    out_dr         = head_inst[11:9];
    out_sr2        = head_inst[2:0];
    out_writes_reg = 1'b0;
    out_is_mem     = 1'b0;
    out_is_ctrl    = 1'b0;
    case (out_opcode)
      OpJsr, OpTrap:       out_dr = 3'b111;
      default:             out_dr = head_inst[11:9];
    endcase
    case (out_opcode)
      OpStb, OpSti, OpStr: out_sr2 = head_inst[11:9];
      default:             out_sr2 = head_inst[2:0];
    endcase
    case (out_opcode)
      OpAdd, OpAnd, OpNot, OpShf, OpLea, OpLdb, OpLdi, OpLdr, OpJsr, OpTrap:
        out_writes_reg = 1'b1;
      default: out_writes_reg = 1'b0;
    endcase
    case (out_opcode)
      OpLdb, OpLdi, OpLdr, OpStb, OpSti, OpStr, OpTrap: out_is_mem = 1'b1;
      default: out_is_mem = 1'b0;
    endcase
    case (out_opcode)
      OpBr, OpJmp, OpJsr, OpTrap, OpRti: out_is_ctrl = 1'b1;
      default: out_is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ipacket_fifo.sv
// Directed self-checking bench for ipacket_fifo (DEPTH=4, WIDTH=16, PC_INC=2).
module tb_ipacket_fifo;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] in_inst, in_pc, out_inst, out_pc_next;
  logic [3:0]  out_opcode;
  logic [2:0]  out_dr, out_sr1, out_sr2;
  logic        out_writes_reg, out_is_mem, out_is_ctrl;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  ipacket_fifo #(.DEPTH(4), .WIDTH(16), .PC_INC(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_inst        (in_inst),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc_next    (out_pc_next),
    .out_opcode     (out_opcode),
    .out_dr         (out_dr),
    .out_sr1        (out_sr1),
    .out_sr2        (out_sr2),
    .out_writes_reg (out_writes_reg),
    .out_is_mem     (out_is_mem),
    .out_is_ctrl    (out_is_ctrl),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Fill to full with ID stalled.
    drive(1'b1, 16'h1283, 16'h3000, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h7A43, 16'h3002, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h4802, 16'h3004, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h5000, 16'h3006, 1'b0, 1'b0); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); #1;
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("add_opcode", 32'(out_opcode), 32'd1);
    check("add_dr", 32'(out_dr), 32'd1);
    check("add_sr1", 32'(out_sr1), 32'd2);
    check("add_sr2", 32'(out_sr2), 32'd3);
    check("add_pc_next", 32'(out_pc_next), 32'h3002);
    check("add_writes", 32'(out_writes_reg), 32'd1);
    check("add_is_mem", 32'(out_is_mem), 32'd0);

    // Hold while full: offered word must not be accepted.
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0); tick();
    check("hold_count", 32'(count), 32'd4);
    check("hold_head", 32'(out_inst), 32'h1283);

    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0); tick();
    check("pop1_count", 32'(count), 32'd3);
    check("str_inst", 32'(out_inst), 32'h7A43);
    check("str_sr2", 32'(out_sr2), 32'd5);
    check("str_is_mem", 32'(out_is_mem), 32'd1);
    check("str_writes", 32'(out_writes_reg), 32'd0);
    check("str_is_ctrl", 32'(out_is_ctrl), 32'd0);
    tick();
    check("jsr_inst", 32'(out_inst), 32'h4802);
    check("jsr_dr", 32'(out_dr), 32'd7);
    check("jsr_is_ctrl", 32'(out_is_ctrl), 32'd1);
    check("jsr_writes", 32'(out_writes_reg), 32'd1);
    check("jsr_pc_next", 32'(out_pc_next), 32'h3006);
    tick();
    check("and_inst", 32'(out_inst), 32'h5000);
    check("and_count", 32'(count), 32'd1);
    tick();
    check("drain_count", 32'(count), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // PC wraparound.
    drive(1'b1, 16'h1283, 16'hFFFE, 1'b0, 1'b0); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); #1;
    check("wrap_pc_next", 32'(out_pc_next), 32'h0000);
    check("wrap_count", 32'(count), 32'd1);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0); tick();
    check("wrap_drain", 32'(count), 32'd0);

    // Throughput across pointer wrap: prefill two, then push and pop together.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 16'h1000 + 16'(k), 16'h4000 + 16'(2 * k), 1'b0, 1'b0);
      tick();
    end
    for (int j = 0; j < 12; j++) begin
      drive(1'b1, 16'h1000 + 16'(j + 2), 16'h4000 + 16'(2 * (j + 2)), 1'b1, 1'b0);
      #1;
      check($sformatf("tp_inst_%0d", j), 32'(out_inst), 32'h1000 + 32'(j));
      check($sformatf("tp_pc_%0d", j), 32'(out_pc_next), 32'h4002 + 32'(2 * j));
      tick();
      check($sformatf("tp_count_%0d", j), 32'(count), 32'd2);
    end
    drive(1'b1, 16'h100E, 16'h401C, 1'b0, 1'b0); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); #1;
    check("pre_flush_count", 32'(count), 32'd3);
    check("pre_flush_head", 32'(out_inst), 32'h100C);

    // Flush beats a concurrent push and pop.
    drive(1'b1, 16'hBEEF, 16'h1234, 1'b1, 1'b1); tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); #1;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("flush_stays_empty", 32'(out_valid), 32'd0);

    // Fill from empty with ID ready: bypass or one-cycle latency.
    drive(1'b1, 16'hE1FF, 16'h2000, 1'b1, 1'b0); #1;
`ifdef IPACKET_FIFO_BYPASS_EN
    check("byp_out_valid", 32'(out_valid), 32'd1);
    check("byp_opcode", 32'(out_opcode), 32'd14);
    check("byp_pc_next", 32'(out_pc_next), 32'h2002);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); #1;
    check("byp_count", 32'(count), 32'd0);
    check("byp_after_valid", 32'(out_valid), 32'd0);
`else
    check("fill_same_cycle_valid", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0); #1;
    check("fill_valid", 32'(out_valid), 32'd1);
    check("fill_count", 32'(count), 32'd1);
    check("lea_opcode", 32'(out_opcode), 32'd14);
    check("lea_inst", 32'(out_inst), 32'hE1FF);
    check("lea_writes", 32'(out_writes_reg), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
